// File: rtl/braun_arith_pkg.sv
// Shared arithmetic definitions for the Braun multiplier/divider family:
// divider FSM state encoding and the legal operand-width check.
package braun_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_N_MIN = 2;
  localparam int DIV_N_MAX = 32;

  // True when n is a supported operand width for the divider.
  function automatic bit div_width_ok(input int n);
    return (n >= DIV_N_MIN) && (n <= DIV_N_MAX);
  endfunction

endpackage

// File: rtl/braun_divider_if.sv
// Operand/result handshake bundle for braun_divider.
// master: the side offering operands and consuming results.
// slave:  the divider itself.
interface braun_divider_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference only when it does not go negative.
module restoring_div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r,
  input  logic         q_in,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N+1:0] t;
  logic [N+1:0] d_ext;
  logic [N:0]   diff;

  // Trial subtraction. The compare is done one bit wider than R so the
  // step stays exact for any R; in normal operation R[N] is always 0 and
  // this reduces to T = {R[N-1:0], q_in} compared against {1'b0, D}.
  always_comb begin
    t      = {r, q_in};
    d_ext  = {2'b00, d};
    diff   = t[N:0] - d_ext[N:0];
    q_bit  = (t >= d_ext);
    r_next = q_bit ? diff : t[N:0];
  end

endmodule

// File: rtl/braun_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock over
// N iterations, valid/ready on both sides, one transaction in flight.
// A zero divisor takes the normal path (quotient all ones, remainder =
// dividend) and is flagged on div_by_zero.
module braun_divider
  import braun_arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  braun_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(N);

  if (!div_width_ok(N)) begin : g_bad_width
    $error("braun_divider: N must be in the range 2..32");
  end

  div_state_t     state_q;
  div_state_t     state_d;

  logic [N-1:0]   q_q;       // dividend being shifted out / quotient shifted in
  logic [N-1:0]   d_q;       // latched divisor
  logic [N:0]     r_q;       // partial remainder
  logic [CNT_W-1:0] cnt_q;   // iterations left after the current one
  logic           dbz_q;

  logic           accept;
  logic [N:0]     step_r;
  logic           step_q_bit;

  assign accept = (state_q == IDLE) && bus.in_valid;

  restoring_div_step #(.N(N)) u_step (
    .r      (r_q),
    .q_in   (q_q[N-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_q_bit)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, N steps in CALC, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = CALC;
      CALC:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Operand load on accept, one restoring step per CALC cycle; registers
  // are untouched in DONE so results hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      q_q   <= bus.dividend;
      d_q   <= bus.divisor;
      r_q   <= '0;
      cnt_q <= CNT_W'(N - 1);
      dbz_q <= (bus.divisor == '0);
    end else if (state_q == CALC) begin
      r_q <= step_r;
      q_q <= {q_q[N-2:0], step_q_bit};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q[N-1:0];
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/braun_divider.md
# braun_divider

Sequential unsigned restoring divider, the inverse of the team's combinational Braun array multiplier. It produces one quotient bit per clock over a fixed N-cycle iteration. Inputs and outputs use valid/ready handshakes so the block can sit behind the multiplier in arithmetic test datapaths. One use is checking products by dividing them back, with `a*b / b == a` for `b != 0`.

## Interface
- `N`, default 4: operand width in bits; legal range 2..32.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: block can accept operands.
- `dividend` input N: unsigned dividend.
- `divisor` input N: unsigned divisor.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `quotient` output N: unsigned quotient.
- `remainder` output N: unsigned remainder.
- `div_by_zero` output 1: the accepted divisor was 0.

## Operation
- FSM states:
  - IDLE -> CALC when `in_valid & in_ready`.
  - CALC -> DONE after N iterations.
  - DONE -> IDLE when `out_ready`.
- `in_ready` = 1 only in IDLE.
- `out_valid` = 1 only in DONE.
- Accept:
  - Latch `divisor` into D (N bits) and `dividend` into Q.
  - Clear partial remainder R (N+1 bits).
  - Load iteration counter with N-1 (width `$clog2(N)`).
  - Register `div_by_zero` = (`divisor == 0`).
- Each CALC cycle performs one restoring step:
  - T = {R[N-1:0], Q[N-1]}.
  - If T >= {1'b0, D}: R <= T - D and shift 1 into Q LSB.
  - Otherwise: R <= T and shift 0 into Q LSB.
  - Q shifts left by one.
  - Counter decrements; when the step runs with counter = 0, next state is DONE.
- Outputs: `quotient` = Q, `remainder` = R[N-1:0]. Both are held stable throughout DONE regardless of input activity.
- Divisor 0 needs no special path:
  - The algorithm naturally yields quotient = all ones and remainder = dividend.
  - `div_by_zero` = 1 flags this case. Latency is unchanged.
- Invariant at DONE when `div_by_zero` = 0:
  - `dividend == quotient*divisor + remainder`.
  - `remainder < divisor`.
- Inputs are ignored outside IDLE, so operand changes during CALC/DONE have no effect.
- Only one transaction is in flight. There is no input buffering.

## Timing
- Reset, when `rst` is sampled high on a rising edge:
  - State goes to IDLE.
  - `in_ready` = 1, `out_valid` = 0.
  - `quotient`, `remainder`, `div_by_zero` and the counter all = 0.
- Reset mid-CALC or mid-DONE aborts the transaction. No `out_valid` pulse is produced for it.
- Reset has priority over all handshakes.
- Latency:
  - Accept occurs at edge k.
  - `out_valid` rises after edge k+N and is visible in the cycle following edge k+N.
- `out_valid` stays high until an edge with `out_ready` = 1. That edge returns the FSM to IDLE, and `in_ready` = 1 from the next cycle.
- Accept and result handoff never happen on the same edge.
- Throughput with `out_ready` held at 1 is one result every N+2 cycles: accept, N CALC cycles, one DONE cycle.
- `in_ready` depends only on state, with no combinational path from `in_valid`.
- `out_valid` depends only on state, with no combinational path from `out_ready`.

## Structure
- Shared package `braun_arith_pkg` holds:
  - The FSM state typedef: `div_state_t` {IDLE, CALC, DONE}, 2-bit encoding.
  - A width-check function that enforces the legal range of N.
- Sub-module `restoring_div_step` holds one combinational step. Parameter N.
  - Inputs: R, next dividend bit, D.
  - Outputs: R_next, q_bit.
- The top level holds the FSM, registers, counter and handshakes.

## Test plan
- N=4, 13/3 with `out_ready`=1 -> `out_valid` in the cycle after edge k+4; `quotient`=4, `remainder`=1, `div_by_zero`=0; `in_ready` returns after DONE.
- N=4, 15/0 -> `quotient`=15, `remainder`=15, `div_by_zero`=1, same latency as a normal divide.
- N=4, 0/5 then 15/1 back-to-back -> results (0,0) then (15,0). Second accept occurs exactly N+2 cycles after the first.
- Backpressure: 9/4 with `out_ready`=0 for 5 cycles in DONE, `in_valid` held high and operands toggled -> results stay at (2,1); no new accept until one cycle after the `out_ready` edge.
- Reset mid-CALC on the 2nd iteration -> next cycle shows `in_ready`=1, `out_valid`=0, all outputs 0. A following 7/2 returns (3,1).
- Exhaustive N=4 sweep of all 256 pairs, plus an N=8 random sweep -> each result matches the reference model `q = a/b`, `r = a%b`, with the divisor-0 rule from Operation.
